dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single-port, async-read, 1024-word data memory between two requesters.
- Port 0 is the pipeline load/store path; port 1 is the DMA/debug path.
- Performs read-modify-write for partial (byte/halfword) stores, so the memory itself only ever sees full-word writes.
- Sits between the requesters and the memory, and drives the memory's write-enable, address and write-data inputs.

Parameters:
- ADDR_W, 10, word-index width; uses addr[ADDR_W+1:2].
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- p0_req / p1_req  in  1  request; held high until the matching ack.
- p0_we / p1_we  in  1  1 = store, 0 = load.
- p0_addr / p1_addr  in  32  byte address; bits [1:0] and above [ADDR_W+1] are ignored.
- p0_wd / p1_wd  in  DATA_W  store data, lane-aligned.
- p0_be / p1_be  in  DATA_W/8  byte enables for stores.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_rd / p1_rd  out  DATA_W  load data; valid in the ack cycle and held until the next ack to that port.
- busy  out  1  high in every state except IDLE.
- cur_id  out  1  id of the transaction in flight (for store logging).
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word index.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  asynchronous memory read data for mem_addr.

Behaviour:
- Reset (synchronous, active-high), effective at the next posedge:
  - state goes to IDLE; rr_last = 1, so port 0 wins the first tie.
  - p0_ack, p1_ack, p0_rd, p1_rd, cur_id and the latched command registers are cleared to 0.
  - An in-flight transaction is dropped: no ack, and no memory write after the reset edge.
- mem_we, mem_addr and mem_wd are combinational from the state registers.
  - In IDLE and RESP: mem_we = 0, mem_addr = 0, mem_wd = 0.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requests: grant the port != rr_last.
  - On grant: latch id, we, word index, wd and be; cur_id <= id; go to ACCESS.
- ACCESS (mem_addr = latched index):
  - Load: rd_buf <= mem_rd; go to RESP.
  - Store with be all-ones: mem_we = 1, mem_wd = wd; go to RESP.
  - Store with partial be: merge_buf <= mem_rd; go to MERGE.
  - Store with be = 0: no write; go to RESP.
- MERGE: mem_we = 1; mem_wd byte k = be[k] ? wd byte k : merge_buf byte k; go to RESP.
- RESP:
  - Pulse ack[id] for one cycle; for a load, pN_rd of that port <= rd_buf.
  - rr_last <= id; go to IDLE.
- Latency from request sampled in IDLE to ack:
  - Load and full-word store: 3 cycles.
  - Partial store: 4 cycles.
- Request rules:
  - req is sampled only in IDLE. A requester must drop or replace its command in the cycle after ack.
  - Re-requesting immediately after ack is legal. The next grant follows the round-robin rule, so under continuous contention the ports alternate.
  - Changing command fields while req is pending and before grant is allowed; the value latched in IDLE is the one used.
- Boundaries:
  - Word index wraps modulo 2^ADDR_W, so address 0x1000 aliases to word 0.
  - A store's memory write takes effect at the posedge ending ACCESS or MERGE. A load granted afterwards sees the new data.
  - No combinational path from any req input to any ack output.

Decomposition:
- Shared package dm_pkg holds:
  - state encoding IDLE = 0, ACCESS = 1, MERGE = 2, RESP = 3;
  - DM_WORDS = 1024;
  - BE_FULL = 4'hF.
- Sub-module be_merge: purely combinational byte-lane merge (old, new, be -> merged). Natural to split out; reusable for lb/sb handling elsewhere.
- FSM, round-robin pointer and output registers stay in the top module.

Test Plan:
- Reset, then p0 full store: p0 store addr=0x10, wd=0x12345678, be=F. Expect mem_we high exactly one cycle with mem_addr=4 and mem_wd=0x12345678, then p0_ack 3 cycles after the request. A following p0 load of 0x10 returns 0x12345678.
- Partial store: word 4 holds 0x12345678; p1 store be=4'b0010, wd=0x0000AB00. Expect a 4-cycle ack, mem_wd=0x1234AB78, and a later read returning 0x1234AB78.
- Simultaneous requests from reset: p0 and p1 both request continuously. Grants go p0, p1, p0, p1; cur_id toggles; no ack is ever given to both ports in the same cycle.
- Reset during MERGE of a be=4'b0001 store: no ack, no memory write, and the word keeps its old value. Both ports then read 0 on p0_rd/p1_rd, and busy=0.
- Edge addresses: store of 0xDEADBEEF at 0xFFC, then load at 0x1000. The load returns word 0 unchanged (aliasing); the load of 0xFFC returns 0xDEADBEEF; mem_addr=1023 is observed.
- Empty store: store with be=0. Ack after 3 cycles, mem_we never asserted, memory unchanged.

Source files
------------

// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// memory depth and the full-word byte-enable pattern.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } dm_state_t;

  localparam int         DM_WORDS = 1024;
  localparam logic [3:0] BE_FULL  = 4'hF;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// One requester port of the data-memory arbiter. The requester drives the
// command side (master); the arbiter answers with ack and load data (slave).
interface dm_port_if #(
  parameter int DATA_W = 32
);

  logic                  req;
  logic                  we;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     wd;
  logic [DATA_W/8-1:0]   be;
  logic                  ack;
  logic [DATA_W-1:0]     rd;

  modport master (
    output req, we, addr, wd, be,
    input  ack, rd
  );

  modport slave (
    input  req, we, addr, wd, be,
    output ack, rd
  );

endinterface

// File: rtl/dm_port_arbiter_be_merge.sv
// Byte-lane merge: every lane whose enable is set takes the new data,
// every other lane keeps the old data. Purely combinational.
module be_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  // Start from the old word and overwrite only the enabled lanes
  always_comb begin
    merged = old_data;
    for (int k = 0; k < DATA_W / 8; k++) begin
      if (be[k]) begin
        merged[8*k +: 8] = new_data[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port async-read data
// memory between the pipeline port (p0) and the DMA/debug port (p1).
// Partial stores are done as read-modify-write so the memory only ever
// sees full-word writes.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  dm_port_if.slave          p0,
  dm_port_if.slave          p1,
  output logic              busy,
  output logic              cur_id,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int              BE_W   = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL = '1;
  localparam logic [BE_W-1:0] BE_NONE = '0;

  dm_state_t         state;
  logic              rr_last;

  logic              cmd_id;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_idx;
  logic [DATA_W-1:0] cmd_wd;
  logic [BE_W-1:0]   cmd_be;

  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] merge_buf;
  logic [DATA_W-1:0] merged_wd;

  logic              p0_ack_q;
  logic              p1_ack_q;
  logic [DATA_W-1:0] p0_rd_q;
  logic [DATA_W-1:0] p1_rd_q;

  logic              grant_valid;
  logic              grant_id;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wd;
  logic [BE_W-1:0]   sel_be;

  logic              unused_addr_bits;

  // Byte offset and bits above the memory depth do not select a word
  assign unused_addr_bits = ^{p0.addr[1:0], p0.addr[31:ADDR_W+2],
                              p1.addr[1:0], p1.addr[31:ADDR_W+2]};

  be_merge #(
    .DATA_W(DATA_W)
  ) u_be_merge (
    .old_data(merge_buf),
    .new_data(cmd_wd),
    .be      (cmd_be),
    .merged  (merged_wd)
  );

  // Pick the winner: a lone requester wins, a tie goes to the port that was not served last
  always_comb begin
    grant_valid = p0.req | p1.req;
    grant_id    = 1'b0;
    if (p0.req && p1.req) begin
      grant_id = ~rr_last;
    end else if (p1.req) begin
      grant_id = 1'b1;
    end
    sel_we   = grant_id ? p1.we   : p0.we;
    sel_addr = grant_id ? p1.addr : p0.addr;
    sel_wd   = grant_id ? p1.wd   : p0.wd;
    sel_be   = grant_id ? p1.be   : p0.be;
  end

  // Sequencer: grant, access memory, optionally merge, then respond with a registered ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      cmd_id    <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_idx   <= '0;
      cmd_wd    <= '0;
      cmd_be    <= '0;
      rd_buf    <= '0;
      merge_buf <= '0;
      p0_ack_q  <= 1'b0;
      p1_ack_q  <= 1'b0;
      p0_rd_q   <= '0;
      p1_rd_q   <= '0;
      cur_id    <= 1'b0;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cmd_id  <= grant_id;
            cmd_we  <= sel_we;
            cmd_idx <= sel_addr[ADDR_W+1:2];
            cmd_wd  <= sel_wd;
            cmd_be  <= sel_be;
            cur_id  <= grant_id;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!cmd_we) begin
            rd_buf <= mem_rd;
            state  <= RESP;
          end else if (cmd_be == BE_ALL || cmd_be == BE_NONE) begin
            state <= RESP;
          end else begin
            merge_buf <= mem_rd;
            state     <= MERGE;
          end
        end
        MERGE: begin
          state <= RESP;
        end
        RESP: begin
          if (cmd_id) begin
            p1_ack_q <= 1'b1;
            if (!cmd_we) p1_rd_q <= rd_buf;
          end else begin
            p0_ack_q <= 1'b1;
            if (!cmd_we) p0_rd_q <= rd_buf;
          end
          rr_last <= cmd_id;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory drive follows the state; a write is suppressed while reset is held so a dropped transaction never lands
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    case (state)
      ACCESS: begin
        mem_addr = cmd_idx;
        if (cmd_we && cmd_be == BE_ALL) begin
          mem_we = 1'b1;
          mem_wd = cmd_wd;
        end
      end
      MERGE: begin
        mem_addr = cmd_idx;
        mem_we   = 1'b1;
        mem_wd   = merged_wd;
      end
      default: begin
      end
    endcase
    if (reset) mem_we = 1'b0;
  end

  assign busy   = (state != IDLE);
  assign p0.ack = p0_ack_q;
  assign p1.ack = p1_ack_q;
  assign p0.rd  = p0_rd_q;
  assign p1.rd  = p1_rd_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: an async-read memory model sits on the memory
// side, and a word-array reference model tracks what memory should hold
// after each completed transaction.
module tb_dm_port_arbiter;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic        cur_id;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem     [DM_WORDS];
  logic [31:0] ref_mem [DM_WORDS];

  int total = 0;
  int bad   = 0;

  int          we_count = 0;
  logic [9:0]  last_we_addr = '0;
  logic [31:0] last_we_wd = '0;
  int          p0_ack_cnt = 0;
  int          p1_ack_cnt = 0;
  bit          saw_1023 = 1'b0;

  dm_port_if #(.DATA_W(32)) p0_if ();
  dm_port_if #(.DATA_W(32)) p1_if ();

  dm_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .p0      (p0_if),
    .p1      (p1_if),
    .busy    (busy),
    .cur_id  (cur_id),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
  );

  always #5 clk = ~clk;

  // Memory environment: async read, write at posedge
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wd;

  // Observe memory writes and acks away from the active edge
  always @(negedge clk) begin
    if (mem_we) begin
      we_count++;
      last_we_addr = mem_addr;
      last_we_wd   = mem_wd;
    end
    if (p0_if.ack) p0_ack_cnt++;
    if (p1_if.ack) p1_ack_cnt++;
    if (mem_addr == 10'd1023) saw_1023 = 1'b1;
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DM_WORDS);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
    logic [31:0] mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic int exp_lat(input bit we, input logic [3:0] be);
    return (we && be != 4'h0 && be != 4'hF) ? 4 : 3;
  endfunction

  task automatic ref_apply(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be);
    if (we) ref_mem[widx(addr)] = ref_merge(ref_mem[widx(addr)], wd, be);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one command on a port and wait for its ack; starts and ends on a negedge
  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output int lat);
    bit got = 1'b0;
    rd  = '0;
    lat = 0;
    if (port) begin
      p1_if.we = we; p1_if.addr = addr; p1_if.wd = wd; p1_if.be = be; p1_if.req = 1'b1;
    end else begin
      p0_if.we = we; p0_if.addr = addr; p0_if.wd = wd; p0_if.be = be; p0_if.req = 1'b1;
    end
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_if.ack : p0_if.ack) begin
        got = 1'b1;
        lat = i;
        rd  = port ? p1_if.rd : p0_if.rd;
      end
    end
    p0_if.req = 1'b0;
    p1_if.req = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("[TB] FAIL ack_timeout: port %0d got no ack within 20 cycles, required an ack", port);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (p0_if.ack !== 1'b0 || p1_if.ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b%b expected 00", p1_if.ack, p0_if.ack); end
    total++; if (p0_if.rd !== 32'h0 || p1_if.rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_rd: got %h/%h expected 0/0", p0_if.rd, p1_if.rd); end
    total++; if (cur_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_cur_id: got %b expected 0", cur_id); end
    total++; if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wd !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_if: got we=%b addr=%0d wd=%h expected 0/0/0", mem_we, mem_addr, mem_wd); end
  endtask

  task automatic test_full_store();
    logic [31:0] rd;
    int lat, w0;
    w0 = we_count;
    do_txn(1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, rd, lat);
    ref_apply(1'b1, 32'h10, 32'h12345678, 4'hF);
    total++; if (lat != exp_lat(1'b1, 4'hF)) begin bad++; $display("[TB] FAIL full_store_lat: got %0d expected %0d", lat, exp_lat(1'b1, 4'hF)); end
    total++; if (we_count - w0 != 1) begin bad++; $display("[TB] FAIL full_store_we_cycles: got %0d expected 1", we_count - w0); end
    total++; if (last_we_addr !== 10'd4) begin bad++; $display("[TB] FAIL full_store_addr: got %0d expected 4", last_we_addr); end
    total++; if (last_we_wd !== ref_mem[4]) begin bad++; $display("[TB] FAIL full_store_wd: got %h expected %h", last_we_wd, ref_mem[4]); end
    do_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, lat);
    total++; if (rd !== 32'h12345678) begin bad++; $display("[TB] FAIL full_store_readback: got %h expected 12345678", rd); end
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL load_lat: got %0d expected 3", lat); end
    @(negedge clk);
    total++; if (p0_if.rd !== 32'h12345678) begin bad++; $display("[TB] FAIL rd_hold: got %h expected 12345678", p0_if.rd); end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd;
    int lat;
    do_txn(1'b1, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, rd, lat);
    ref_apply(1'b1, 32'h10, 32'h0000AB00, 4'b0010);
    total++; if (lat != 4) begin bad++; $display("[TB] FAIL partial_lat: got %0d expected 4", lat); end
    total++; if (last_we_wd !== 32'h1234AB78) begin bad++; $display("[TB] FAIL partial_wd: got %h expected 1234ab78", last_we_wd); end
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, lat);
    total++; if (rd !== ref_mem[4]) begin bad++; $display("[TB] FAIL partial_readback: got %h expected %h", rd, ref_mem[4]); end
  endtask

  task automatic test_contention();
    logic [31:0] cur_addr [2];
    logic [31:0] rd;
    int  acks = 0;
    bit  exp_id = 1'b0;
    bit  id;
    apply_reset();
    cur_addr[0] = $urandom_range(0, 1022) * 4;
    cur_addr[1] = $urandom_range(0, 1022) * 4;
    p0_if.we = 1'b0; p0_if.addr = cur_addr[0]; p0_if.be = 4'h0; p0_if.req = 1'b1;
    p1_if.we = 1'b0; p1_if.addr = cur_addr[1]; p1_if.be = 4'h0; p1_if.req = 1'b1;
    for (int i = 0; i < 80 && acks < 6; i++) begin
      @(negedge clk);
      if (p0_if.ack && p1_if.ack) begin
        total++; bad++;
        $display("[TB] FAIL dual_ack: got both acks high, required at most one");
      end else if (p0_if.ack || p1_if.ack) begin
        id = p1_if.ack;
        rd = id ? p1_if.rd : p0_if.rd;
        total++; if (id !== exp_id) begin bad++; $display("[TB] FAIL rr_order: got port %0d expected port %0d", id, exp_id); end
        total++; if (cur_id !== id) begin bad++; $display("[TB] FAIL cur_id: got %b expected %b", cur_id, id); end
        total++; if (rd !== ref_mem[widx(cur_addr[id])]) begin bad++; $display("[TB] FAIL contention_rd: got %h expected %h", rd, ref_mem[widx(cur_addr[id])]); end
        cur_addr[id] = $urandom_range(0, 1022) * 4;
        if (id) p1_if.addr = cur_addr[1]; else p0_if.addr = cur_addr[0];
        exp_id = ~exp_id;
        acks++;
      end
    end
    p0_if.req = 1'b0;
    p1_if.req = 1'b0;
    total++; if (acks != 6) begin bad++; $display("[TB] FAIL contention_acks: got %0d expected 6", acks); end
  endtask

  task automatic test_reset_in_merge();
    logic [31:0] addr, wd, rd;
    int w0, a0, a1, lat;
    addr = $urandom_range(0, 1022) * 4;
    wd   = $urandom;
    w0 = we_count;
    p0_if.we = 1'b1; p0_if.addr = addr; p0_if.wd = wd; p0_if.be = 4'b0001; p0_if.req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL merge_busy: got %b expected 1", busy); end
    reset = 1'b1;
    p0_if.req = 1'b0;
    @(negedge clk);
    a0 = p0_ack_cnt; a1 = p1_ack_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (p0_ack_cnt != a0 || p1_ack_cnt != a1) begin bad++; $display("[TB] FAIL merge_reset_ack: got %0d acks expected 0", p0_ack_cnt - a0 + p1_ack_cnt - a1); end
    total++; if (we_count != w0) begin bad++; $display("[TB] FAIL merge_reset_write: got %0d writes expected 0", we_count - w0); end
    total++; if (p0_if.rd !== 32'h0 || p1_if.rd !== 32'h0) begin bad++; $display("[TB] FAIL merge_reset_rd: got %h/%h expected 0/0", p0_if.rd, p1_if.rd); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL merge_reset_busy: got %b expected 0", busy); end
    do_txn(1'b1, 1'b0, addr, 32'h0, 4'h0, rd, lat);
    total++; if (rd !== ref_mem[widx(addr)]) begin bad++; $display("[TB] FAIL merge_reset_word: got %h expected %h", rd, ref_mem[widx(addr)]); end
  endtask

  task automatic test_edge_addr();
    logic [31:0] rd;
    int lat;
    do_txn(1'b0, 1'b1, 32'hFFC, 32'hDEADBEEF, 4'hF, rd, lat);
    ref_apply(1'b1, 32'hFFC, 32'hDEADBEEF, 4'hF);
    total++; if (saw_1023 !== 1'b1) begin bad++; $display("[TB] FAIL edge_addr_1023: got seen=%b expected 1", saw_1023); end
    do_txn(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, rd, lat);
    total++; if (rd !== ref_mem[0]) begin bad++; $display("[TB] FAIL edge_alias: got %h expected %h", rd, ref_mem[0]); end
    do_txn(1'b0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, lat);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL edge_top: got %h expected deadbeef", rd); end
  endtask

  task automatic test_empty_store();
    logic [31:0] addr, rd;
    int lat, w0;
    addr = $urandom_range(0, 1022) * 4;
    w0 = we_count;
    do_txn(1'b1, 1'b1, addr, $urandom, 4'h0, rd, lat);
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL empty_lat: got %0d expected 3", lat); end
    total++; if (we_count != w0) begin bad++; $display("[TB] FAIL empty_write: got %0d writes expected 0", we_count - w0); end
    do_txn(1'b0, 1'b0, addr, 32'h0, 4'h0, rd, lat);
    total++; if (rd !== ref_mem[widx(addr)]) begin bad++; $display("[TB] FAIL empty_unchanged: got %h expected %h", rd, ref_mem[widx(addr)]); end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd, exp;
    logic [3:0]  be;
    bit          port, we;
    int          lat, w0;
    for (int n = 0; n < 30; n++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 7) * 4 + $urandom_range(0, 3) + $urandom_range(0, 1) * 32'h1000;
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      exp  = ref_mem[widx(addr)];
      w0   = we_count;
      do_txn(port, we, addr, wd, be, rd, lat);
      ref_apply(we, addr, wd, be);
      total++; if (lat != exp_lat(we, be)) begin bad++; $display("[TB] FAIL rand_lat: got %0d expected %0d (we=%b be=%h)", lat, exp_lat(we, be), we, be); end
      if (we) begin
        total++; if (we_count - w0 != ((be != 4'h0) ? 1 : 0)) begin bad++; $display("[TB] FAIL rand_writes: got %0d expected %0d (be=%h)", we_count - w0, (be != 4'h0) ? 1 : 0, be); end
      end else begin
        total++; if (rd !== exp) begin bad++; $display("[TB] FAIL rand_load: got %h expected %h (addr=%h)", rd, exp, addr); end
      end
    end
  endtask

  // Global bound so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wd = '0; p0_if.be = '0;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wd = '0; p1_if.be = '0;
    for (int i = 0; i < DM_WORDS; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    @(negedge clk);
    test_reset();
    test_full_store();
    test_partial_store();
    test_contention();
    test_reset_in_merge();
    test_edge_addr();
    test_empty_store();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
